// File: rtl/ysyx_22040759_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - reset PC, queue depth, data widths
//   - IFU FSM state encoding (REQ / WAIT / DROP)
//   - queue entry layout {pc, inst}
//   - word-alignment helper for redirect targets
package ysyx_22040759_ifu_pkg;

    localparam int XLEN          = 32;
    localparam int INST_W        = 32;
    localparam int IFU_BUF_DEPTH = 2;

    localparam logic [XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;

    // REQ : may present a fetch request
    // WAIT: one fetch outstanding, its response will be queued
    // DROP: one fetch outstanding, its response is stale and discarded
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifu_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22040759_ifu_fifo.sv
// Two-entry {pc, inst} queue between fetch and decode.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail (ignored when full and not popping)
//   pop         : remove the head (ignored when empty)
//   flush       : empty the queue; wins over push
//   push_data   : entry to write
//   head        : current head entry; holds its last value while empty
//   count       : number of valid entries (0..2)
//   empty       : count == 0
// Entry 0 is always the head, so the output is a plain register and keeps
// showing the last instruction after the queue drains.
module ysyx_22040759_ifu_fifo
    import ysyx_22040759_ifu_pkg::*;
#(
    parameter int DEPTH = IFU_BUF_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  ifu_entry_t push_data,
    output ifu_entry_t head,
    output logic [1:0] count,
    output logic       empty
);

    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    ifu_entry_t e0_q, e1_q, e0_d, e1_d;
    logic [1:0] count_q, count_d;
    logic       full, do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (flush) begin
            // Data registers are left alone so head keeps its last value.
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = push_data;
                    else                 e1_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) e0_d = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_d = push_data;
                    end else begin
                        e0_d = e1_q;
                        e1_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign head  = e0_q;
    assign count = count_q;

endmodule

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from
// instruction memory and queues {pc, inst} pairs toward decode.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         : fetch request channel
//   imem_rsp_valid/data               : fetch response (always accepted)
//   redirect_valid/pc                 : control-flow change from execute
//   inst_valid/ready, inst, inst_pc   : queue head toward decode
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Once raised, imem_req_valid stays high with a stable address until it is
// accepted; only a redirect may change the address. At most one fetch is
// ever outstanding, and a fetch is only requested when the queue has room
// for its response, so the queue never overflows.
module ysyx_22040759_ifu
    import ysyx_22040759_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
    parameter int          BUF_DEPTH = IFU_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam logic [1:0] BUF_CNT = 2'(BUF_DEPTH);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q;
    logic        started_q;
    logic        req_fire;
    logic        push, pop;
    ifu_entry_t  push_data, head;
    logic [1:0]  fifo_count;
    logic        fifo_empty;

    always_comb begin
        // started_q keeps the request low for the first cycle after reset release.
        imem_req_valid = started_q && (state_q == ST_REQ) && (fifo_count < BUF_CNT);
        req_fire       = imem_req_valid && imem_req_ready;
        state_d        = state_q;
        pc_d           = pc_q;
        push           = 1'b0;

        case (state_q)
            ST_REQ: begin
                // A fetch accepted in the redirect cycle belongs to the old path.
                if (req_fire) state_d = redirect_valid ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                    push    = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase

        if (redirect_valid) pc_d = align_word(redirect_pc);
        else if (req_fire)  pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            started_q <= 1'b1;
            if (req_fire) req_pc_q <= pc_q;
        end
    end

    assign push_data.pc   = req_pc_q;
    assign push_data.inst = imem_rsp_data;
    assign pop            = inst_valid && inst_ready;

    ysyx_22040759_ifu_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_data),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign imem_req_addr = pc_q;
    assign inst_valid    = !fifo_empty;
    assign inst          = head.inst;
    assign inst_pc       = head.pc;

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
`timescale 1ns/1ps
module tb_ysyx_22040759_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ysyx_22040759_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // ---------------- environment knobs ----------------
    int ready_pct = 100;
    bit stall     = 1'b0;
    int lat_min   = 0;
    int lat_max   = 0;
    int cons_mode = 0;   // 0: always ready, 1: never ready, 2: random

    logic [31:0] hs_log[$];    // accepted request addresses
    logic [31:0] cons_pc[$];   // pc of each instruction decode consumed
    int          cons_cyc[$];  // cycle of each consumption
    int          n_consumed = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // ---------------- memory model + request checker ----------------
    initial begin : mem_model
        logic        hs;
        logic [31:0] hs_addr;
        bit          pending;
        int          delay;
        logic [31:0] pend_addr;
        logic [31:0] exp_req;
        bit          held;
        logic [31:0] held_addr;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        hs = 1'b0; hs_addr = '0; pending = 1'b0; delay = 0; pend_addr = '0;
        exp_req = RST_PC; held = 1'b0; held_addr = '0;
        forever begin
            @(negedge clk);
            hs = 1'b0;
            if (!rst_n) begin
                exp_req = RST_PC;
                held    = 1'b0;
            end else begin
                if (held) begin
                    n_checks++;
                    if (imem_req_valid !== 1'b1 || imem_req_addr !== held_addr) begin
                        n_fail++;
                        $display("FAIL req_hold: valid=%b addr=%h, required valid=1 addr=%h",
                                 imem_req_valid, imem_req_addr, held_addr);
                    end
                end
                if (imem_req_valid === 1'b1 && imem_req_ready) begin
                    hs      = 1'b1;
                    hs_addr = imem_req_addr;
                    hs_log.push_back(hs_addr);
                    n_checks++;
                    if (hs_addr !== exp_req) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h, required %h", hs_addr, exp_req);
                    end
                    n_checks++;
                    if (pending || imem_rsp_valid) begin
                        n_fail++;
                        $display("FAIL one_outstanding: request %h issued while a fetch is in flight", hs_addr);
                    end
                    exp_req = exp_req + 32'd4;
                end
                held      = (imem_req_valid === 1'b1) && !imem_req_ready && !redirect_valid;
                held_addr = imem_req_addr;
                if (redirect_valid) exp_req = {redirect_pc[31:2], 2'b00};
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (hs) begin
                    pending   = 1'b1;
                    pend_addr = hs_addr;
                    delay     = int'($urandom_range(lat_min, lat_max));
                end
                if (pending) begin
                    if (delay == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_data(pend_addr);
                        pending        = 1'b0;
                    end else begin
                        delay--;
                    end
                end
            end
            imem_req_ready = stall ? 1'b0 : (int'($urandom_range(1, 100)) <= ready_pct);
        end
    end

    // ---------------- decode model + scoreboard ----------------
    initial begin : consumer
        logic [31:0] exp_pc;
        bit          after_redir;
        exp_pc = RST_PC;
        after_redir = 1'b0;
        inst_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc      = RST_PC;
                after_redir = 1'b0;
            end else begin
                if (after_redir) begin
                    n_checks++;
                    if (inst_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL flush_inst_valid: inst_valid=%b the cycle after redirect, required 0", inst_valid);
                    end
                end
                if (inst_valid === 1'b1 && inst_ready) begin
                    n_checks++;
                    if (inst_pc !== exp_pc || inst !== mem_data(exp_pc)) begin
                        n_fail++;
                        $display("FAIL decode_stream: pc=%h inst=%h, required pc=%h inst=%h",
                                 inst_pc, inst, exp_pc, mem_data(exp_pc));
                    end
                    cons_pc.push_back(inst_pc);
                    cons_cyc.push_back(cyc);
                    n_consumed++;
                    exp_pc = exp_pc + 32'd4;
                end
                after_redir = redirect_valid;
                if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            end
            @(posedge clk);
            #1;
            case (cons_mode)
                0:       inst_ready = 1'b1;
                1:       inst_ready = 1'b0;
                default: inst_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid); end
        n_checks++;
        if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h, required %h", imem_req_addr, RST_PC); end
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b, required 0", inst_valid); end
        n_checks++;
        if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h, required 0", inst); end
        n_checks++;
        if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h, required 0", inst_pc); end
        hs_log.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10 && imem_req_valid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL first_request: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int base;
        base = n_consumed;
        for (int i = 0; i < 60 && n_consumed < base + 6; i++) @(negedge clk);
        n_checks++;
        if (n_consumed < base + 6) begin
            n_fail++;
            $display("FAIL stream_progress: consumed %0d, required %0d", n_consumed - base, 6);
        end else begin
            n_checks++;
            if (cons_cyc[base + 5] - cons_cyc[base] != 10) begin
                n_fail++;
                $display("FAIL stream_rate: 5 gaps took %0d cycles, required 10", cons_cyc[base + 5] - cons_cyc[base]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (hs_log.size() <= k || hs_log[k] !== RST_PC + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL stream_addr%0d: log size %0d, required addr %h", k, hs_log.size(), RST_PC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        logic v0, v1, v2;
        int   base;
        cons_mode = 1;
        repeat (12) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_full: req_valid=%b inst_valid=%b, required 0 and 1", imem_req_valid, inst_valid);
            end
        end
        base = n_consumed;
        cons_mode = 0;
        @(negedge clk) v0 = inst_valid;
        @(negedge clk) v1 = inst_valid;
        @(negedge clk) v2 = inst_valid;
        n_checks++;
        if ({v0, v1, v2} !== 3'b110) begin
            n_fail++;
            $display("FAIL bp_drain_valid: inst_valid over 3 cycles=%b, required 110", {v0, v1, v2});
        end
        n_checks++;
        if (n_consumed - base != 2) begin
            n_fail++;
            $display("FAIL bp_drain_count: drained %0d, required 2", n_consumed - base);
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_req_stall();
        logic [31:0] a;
        int          sz;
        stall = 1'b1;
        for (int i = 0; i < 20 && !(imem_req_valid === 1'b1 && imem_req_ready === 1'b0); i++) @(negedge clk);
        a = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%b addr=%h, required 1 and %h", imem_req_valid, imem_req_addr, a);
            end
        end
        sz = hs_log.size();
        stall = 1'b0;
        for (int i = 0; i < 10 && hs_log.size() <= sz; i++) @(negedge clk);
        n_checks++;
        if (hs_log.size() <= sz || hs_log[sz] !== a) begin
            n_fail++;
            $display("FAIL stall_accept: log size %0d, required accepted addr %h", hs_log.size(), a);
        end
    endtask

    task automatic test_redirect(input int mode, input logic [31:0] target);
        // mode 0: redirect while in WAIT, mode 1: with rsp, mode 2: with req handshake
        int          base, sz;
        logic [31:0] aligned;
        aligned = {target[31:2], 2'b00};
        lat_min = (mode == 0) ? 3 : 0;
        lat_max = lat_min;
        if (mode == 2) begin
            for (int i = 0; i < 20 && imem_rsp_valid !== 1'b1; i++) @(negedge clk);
        end else begin
            for (int i = 0; i < 20 && !(imem_req_valid === 1'b1 && imem_req_ready === 1'b1); i++) @(negedge clk);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        if (mode == 2) begin
            n_checks++;
            if (imem_req_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL redir_hs_setup: req_valid=%b in redirect cycle, required 1", imem_req_valid);
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        base = n_consumed;
        sz   = hs_log.size();
        lat_min = 0;
        lat_max = 0;
        for (int i = 0; i < 30 && hs_log.size() <= sz; i++) @(negedge clk);
        n_checks++;
        if (hs_log.size() <= sz || hs_log[sz] !== aligned) begin
            n_fail++;
            $display("FAIL redir%0d_next_addr: log size %0d, required %h", mode, hs_log.size(), aligned);
        end
        for (int i = 0; i < 30 && n_consumed <= base; i++) @(negedge clk);
        n_checks++;
        if (n_consumed <= base || cons_pc[base] !== aligned) begin
            n_fail++;
            $display("FAIL redir%0d_first_inst: consumed %0d, required first pc %h", mode, n_consumed - base, aligned);
        end
    endtask

    task automatic test_back_to_back();
        int base, sz;
        @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_pc = 32'h8000_4000;
        @(posedge clk);
        #1 redirect_pc = 32'h8000_5002;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        base = n_consumed;
        sz   = hs_log.size();
        for (int i = 0; i < 30 && hs_log.size() <= sz; i++) @(negedge clk);
        n_checks++;
        if (hs_log.size() <= sz || hs_log[sz] !== 32'h8000_5000) begin
            n_fail++;
            $display("FAIL b2b_next_addr: log size %0d, required 80005000", hs_log.size());
        end
        for (int i = 0; i < 30 && n_consumed <= base; i++) @(negedge clk);
        n_checks++;
        if (n_consumed <= base || cons_pc[base] !== 32'h8000_5000) begin
            n_fail++;
            $display("FAIL b2b_first_inst: consumed %0d, required first pc 80005000", n_consumed - base);
        end
    endtask

    task automatic test_wrap();
        int sz;
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        sz = hs_log.size();
        for (int i = 0; i < 40 && hs_log.size() < sz + 3; i++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (hs_log.size() <= sz + k || hs_log[sz + k] !== want[k]) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: log size %0d, required %h", k, hs_log.size(), want[k]);
            end
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_random();
        int base;
        base = n_consumed;
        ready_pct = 60; lat_min = 0; lat_max = 2; cons_mode = 2;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        ready_pct = 100; lat_min = 0; lat_max = 0; cons_mode = 0;
        repeat (20) @(posedge clk);
        n_checks++;
        if (n_consumed - base < 20) begin
            n_fail++;
            $display("FAIL random_progress: consumed %0d, required at least 20", n_consumed - base);
        end
    endtask

    task automatic test_async_reset();
        int base;
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 20 && !(imem_req_valid === 1'b1 && imem_req_ready === 1'b1); i++) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL areset_req: valid=%b addr=%h, required 0 and %h", imem_req_valid, imem_req_addr, RST_PC);
        end
        n_checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_inst: valid=%b inst=%h pc=%h, required 0/0/0", inst_valid, inst, inst_pc);
        end
        lat_min = 0; lat_max = 0;
        repeat (2) @(posedge clk);
        base = n_consumed;
        hs_log.delete();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 30 && n_consumed < base + 3; i++) @(negedge clk);
        n_checks++;
        if (n_consumed < base + 3 || cons_pc[base] !== RST_PC) begin
            n_fail++;
            $display("FAIL areset_restart: consumed %0d, required first pc %h", n_consumed - base, RST_PC);
        end
        n_checks++;
        if (hs_log.size() == 0 || hs_log[0] !== RST_PC) begin
            n_fail++;
            $display("FAIL areset_first_req: log size %0d, required first addr %h", hs_log.size(), RST_PC);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect(0, 32'h8000_0103);
        test_redirect(1, 32'h8000_2000);
        test_redirect(2, 32'h8000_3000);
        test_back_to_back();
        test_wrap();
        test_random();
        test_async_reset();
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
